fetch_queue: RTL
================

# fetch_queue

Receive side of the instruction-fetch interface. Accepts fetched (pc, instruction) pairs from the fetch unit under a valid/ready handshake and buffers them in a small FIFO. Presents them in order to the decode stage, which stalls via out_ready on data hazards. A taken branch flushes every buffered entry and inserts NOP bubbles. Sits between the IF stage and the ID stage and replaces a bare IF/ID latch.

## Interface
Clock is clk; reset is rst, asynchronous, active-high.

Parameters:
- DEPTH, default 2: number of entries; must be a power of 2 and at least 2.
- NOP, default 32'h0000_0013: instruction driven when the queue is empty (addi x0,x0,0).

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: asynchronous active-high reset.
- in_valid, input, 1: fetch presents a valid pair this cycle.
- in_pc, input, 32: pc of the fetched instruction.
- in_instruction, input, 32: fetched instruction word.
- in_ready, output, 1: queue can accept a pair this cycle.
- flush, input, 1: taken branch; discard all contents.
- out_valid, output, 1: head entry valid for decode.
- out_pc, output, 32: pc of the head entry.
- out_instruction, output, 32: instruction of the head entry; NOP when empty.
- out_ready, input, 1: decode consumes the head; low while decode is stalled on a hazard.
- count, output, $clog2(DEPTH)+1: current occupancy.

## Operation
- Storage: DEPTH-entry circular buffer of {pc, instruction}.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap modulo DEPTH naturally.
  - count tracks occupancy, range 0..DEPTH.
- in_ready = (count != DEPTH). This is purely a function of registered state; there is no combinational path from out_ready or flush.
- out_valid = (count != 0).
  - When out_valid=1: out_pc and out_instruction come from the entry at rd_ptr.
  - When out_valid=0: out_pc=32'd0 and out_instruction=NOP.
- push = in_valid & in_ready & ~flush. On push, write the entry at wr_ptr and increment wr_ptr.
- pop = out_valid & out_ready & ~flush. On pop, increment rd_ptr.
- count_next = count + push - pop. A simultaneous push and pop leaves count unchanged.
- flush has priority over everything:
  - wr_ptr, rd_ptr and count return to 0 on the next edge.
  - Any in_valid in the flush cycle is dropped, not stored.
  - No pop occurs in the flush cycle.
- There is no bypass path. A pair pushed into an empty queue appears at the output one cycle later.
- Storage contents are not cleared by reset or flush; only pointers and count are.

## Timing
- Reset values (asserted asynchronously): count=0, wr_ptr=0, rd_ptr=0, in_ready=1, out_valid=0, out_pc=0, out_instruction=NOP.
- Latency: a push at edge N gives out_valid=1 with that pair after edge N. Minimum fetch-to-decode latency is one cycle.
- Throughput: one push and one pop per cycle is sustained indefinitely when out_ready=1.
- Full (count=DEPTH):
  - in_ready=0, even if out_ready=1 in the same cycle.
  - A pop during full deasserts in_ready's blocking condition on the following cycle.
- Empty (count=0): out_ready is ignored; no pop and no underflow.
- Simultaneous flush and push: the push is dropped; count=0 after the edge.
- Simultaneous flush and pop: the pop is suppressed; count=0 after the edge.
- Flush while empty: no effect other than dropping in_valid.
- Reset mid-operation (rst rising at any point): state goes to reset values immediately, without waiting for clk. The first push is accepted on the first clk edge after rst deasserts.
- Pointer wrap: entries are delivered in order across the DEPTH-1 → 0 boundary for any number of wraps.

## Test plan
- Reset and idle:
  - Stimulus: assert rst mid-cycle with the queue holding 2 entries.
  - Required: count=0, out_valid=0, out_instruction=32'h0000_0013 and in_ready=1 immediately, before the next clk edge.
- Streaming:
  - Stimulus: in_valid=1 with pc 0,4,8,…,60 and out_ready=1 throughout.
  - Required: out_pc follows the input one cycle late; count stays 1; all 16 pairs arrive in order across pointer wraps.
- Stall/full:
  - Stimulus: out_ready=0, push pc 0x0, 0x4, then offer 0x8.
  - Required: count=2, in_ready=0, 0x8 not accepted.
  - Then raise out_ready for one cycle.
  - Required: 0x0 is consumed; 0x8 is accepted on the next cycle; the output sequence is 0x4 then 0x8.
- Flush:
  - Stimulus: queue holding pc 0x10 and 0x14; assert flush together with in_valid for pc 0x18.
  - Required: next cycle count=0, out_valid=0, out_instruction=NOP; 0x18 is never output.
  - Then push branch target 0x100.
  - Required: out_pc=0x100 one cycle later.
- Simultaneous push/pop at count=1:
  - Required: count stays 1, and the output advances to the newer pc on the next cycle.
- Empty pop:
  - Stimulus: out_ready=1 with count=0 for 3 cycles.
  - Required: count stays 0, pointers unchanged, and the next push is delivered correctly.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: IF->ID instruction buffer with valid/ready handshake; flush empties it and NOP is driven while empty
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter logic [31:0] NOP = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instruction,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instruction,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0] pc_mem [DEPTH];
  logic [31:0] ins_mem [DEPTH];
  logic push, pop;
  assign in_ready = count != FULL;
  assign out_valid = count != '0;
  assign push = in_valid & in_ready & ~flush;
  assign pop = out_valid & out_ready & ~flush;
  assign out_pc = out_valid ? pc_mem[rd_ptr] : '0;
  assign out_instruction = out_valid ? ins_mem[rd_ptr] : NOP;
  // storage is never cleared; only pointers and occupancy are reset
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr] <= in_pc;
      ins_mem[wr_ptr] <= in_instruction;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
    end
  end
endmodule
